// File: rtl/fir_output_capture.sv
// Captures a programmed number of FIR output samples after a settle period,
// buffers them in a show-ahead FIFO and tracks the peak written value.
module fir_output_capture #(
  parameter int DW     = 16,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 3
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [DW-1:0]            y_in,
  input  logic                     start,
  input  logic [7:0]               num_samples,
  output logic                     busy,
  output logic                     done,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            peak,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
  localparam logic [7:0]    SETTLE_CNT = 8'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_settle, w_settle_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [7:0]        r_n, w_n_nxt;
  logic              w_start_acc;

  logic [DW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr, w_rptr_nxt;
  logic [LW-1:0]     r_level, w_level_nxt, w_remain;
  logic [DW-1:0]     r_out_data, w_head_nxt;
  logic [DW-1:0]     r_peak, w_peak_nxt;
  logic              r_ovf, r_valid, r_busy, r_done;
  logic              w_full, w_pop, w_cap, w_wr, w_drop;

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_cnt_nxt    = r_cnt;
    w_n_nxt      = r_n;
    w_start_acc  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_n_nxt     = num_samples;
          w_cnt_nxt   = 8'd0;
          if (num_samples == 8'd0) begin
            w_state_nxt = S_DONE;
          end else if (SETTLE == 0) begin
            w_state_nxt = S_CAPTURE;
          end else begin
            w_state_nxt  = S_SETTLE;
            w_settle_nxt = SETTLE_CNT;
          end
        end
      end
      S_SETTLE: begin
        w_settle_nxt = r_settle - 8'd1;
        if (r_settle <= 8'd1) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_cnt_nxt = r_cnt + 8'd1;
        if ((r_cnt + 8'd1) >= r_n) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A full FIFO still accepts a capture sample when the reader pops in the same cycle.
  always_comb begin
    w_full      = (r_level == FULL_LVL);
    w_pop       = r_valid & out_ready;
    w_cap       = (r_state == S_CAPTURE);
    w_wr        = w_cap & (~w_full | w_pop);
    w_drop      = w_cap & w_full & ~w_pop;
    w_rptr_nxt  = w_pop ? (r_rptr + AW'(1)) : r_rptr;
    w_remain    = r_level - (w_pop ? LW'(1) : '0);
    w_level_nxt = w_remain + (w_wr ? LW'(1) : '0);
    if (w_remain == '0) begin
      w_head_nxt = w_wr ? y_in : r_out_data;
    end else begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
    w_peak_nxt = r_peak;
    if (w_start_acc) begin
      w_peak_nxt = '0;
    end else if (w_wr && (y_in > r_peak)) begin
      w_peak_nxt = y_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= y_in;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state    <= S_IDLE;
      r_settle   <= 8'd0;
      r_cnt      <= 8'd0;
      r_n        <= 8'd0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_out_data <= '0;
      r_peak     <= '0;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_settle   <= w_settle_nxt;
      r_cnt      <= w_cnt_nxt;
      r_n        <= w_n_nxt;
      r_wptr     <= w_wr ? (r_wptr + AW'(1)) : r_wptr;
      r_rptr     <= w_rptr_nxt;
      r_level    <= w_level_nxt;
      r_out_data <= w_head_nxt;
      r_peak     <= w_peak_nxt;
      r_ovf      <= w_start_acc ? 1'b0 : (r_ovf | w_drop);
      r_valid    <= (w_level_nxt != '0);
      r_busy     <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_CAPTURE);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_data  = r_out_data;
  assign out_valid = r_valid;
  assign peak      = r_peak;
  assign overflow  = r_ovf;
  assign level     = r_level;

endmodule
